// File: rtl/rx_cmd_parser.sv
// rtl/rx_cmd_parser.sv - ASCII command frame parser with show-ahead command FIFO
// Frames are <A hex><B hex><opcode char><TERM>; decoded {a,b,op} entries queue for the ALU side.
module rx_cmd_parser #(
   parameter int          DATA_W = 8,
   parameter int          DEPTH  = 4,
   parameter logic [7:0]  TERM   = 8'h0D
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rx_done_tick,
   input  logic [7:0]                 dout,
   input  logic                       rd,
   output logic [DATA_W-1:0]          a,
   output logic [DATA_W-1:0]          b,
   output logic [5:0]                 op,
   output logic                       cmd_empty,
   output logic                       cmd_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err,
   output logic                       ovf
);

   localparam int ND = DATA_W / 4;
   localparam int DW = $clog2(ND + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * DATA_W + 6;

   typedef enum logic [2:0] {GET_A, GET_B, GET_OP, GET_TERM, SYNC} state_t;

   state_t              state, state_nx;
   logic [DW-1:0]       cnt, cnt_nx;
   logic [DATA_W-1:0]   a_sh, a_nx, b_sh, b_nx;
   logic [5:0]          op_sh, op_nx;
   logic [DATA_W+3:0]   a_cat, b_cat;
   logic                is_hex, is_op, last, push, bad;
   logic [3:0]          nib;
   logic [5:0]          op_code;

   logic [EW-1:0]       mem [DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [EW-1:0]       head;
   logic                do_push, do_pop, drop;

   always_comb begin
      is_hex = 1'b1;
      nib    = 4'd0;
      if (dout >= 8'h30 && dout <= 8'h39)
         nib = dout[3:0];
      else if ((dout >= 8'h61 && dout <= 8'h66) || (dout >= 8'h41 && dout <= 8'h46))
         nib = dout[3:0] + 4'd9;
      else
         is_hex = 1'b0;
   end

   always_comb begin
      is_op   = 1'b1;
      op_code = 6'd0;
      case (dout)
         8'h2B:   op_code = 6'b100000;
         8'h2D:   op_code = 6'b100010;
         8'h26:   op_code = 6'b100100;
         8'h7C:   op_code = 6'b100101;
         8'h5E:   op_code = 6'b100110;
         8'h7E:   op_code = 6'b100111;
         8'h3C:   op_code = 6'b000010;
         8'h3E:   op_code = 6'b000011;
         default: is_op   = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      a_nx     = a_sh;
      b_nx     = b_sh;
      op_nx    = op_sh;
      push     = 1'b0;
      bad      = 1'b0;
      a_cat    = {a_sh, nib};
      b_cat    = {b_sh, nib};
      last     = (cnt == DW'(ND - 1));
      if (rx_done_tick) begin
         case (state)
            GET_A:
               if (is_hex) begin
                  a_nx = a_cat[DATA_W-1:0];
                  if (last) begin
                     cnt_nx   = '0;
                     state_nx = GET_B;
                  end else begin
                     cnt_nx = cnt + DW'(1);
                  end
               end else if (!(dout == TERM && cnt == '0)) begin
                  bad = 1'b1;
               end
            GET_B:
               if (is_hex) begin
                  b_nx = b_cat[DATA_W-1:0];
                  if (last) begin
                     cnt_nx   = '0;
                     state_nx = GET_OP;
                  end else begin
                     cnt_nx = cnt + DW'(1);
                  end
               end else begin
                  bad = 1'b1;
               end
            GET_OP:
               if (is_op) begin
                  op_nx    = op_code;
                  state_nx = GET_TERM;
               end else begin
                  bad = 1'b1;
               end
            GET_TERM:
               if (dout == TERM) begin
                  push     = 1'b1;
                  state_nx = GET_A;
               end else begin
                  bad = 1'b1;
               end
            SYNC:
               if (dout == TERM) state_nx = GET_A;
            default: state_nx = GET_A;
         endcase
         // A stray TERM already marks a frame boundary, so no resync is needed.
         if (bad) begin
            cnt_nx   = '0;
            state_nx = (dout == TERM) ? GET_A : SYNC;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= GET_A;
         cnt   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         op_sh <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         a_sh  <= a_nx;
         b_sh  <= b_nx;
         op_sh <= op_nx;
      end
   end

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
   assign do_pop  = rd & ~cmd_empty;
   assign do_push = push & (~cmd_full | do_pop);
   assign drop    = push & cmd_full & ~do_pop;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= {a_sh, b_sh, op_sh};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         err <= bad;
         ovf <= drop;
      end
   end

   assign cmd_empty = (count == '0);
   assign cmd_full  = (count == CW'(DEPTH));
   assign head      = mem[rd_ptr];
   assign a         = cmd_empty ? '0 : head[EW-1 -: DATA_W];
   assign b         = cmd_empty ? '0 : head[DATA_W+5 -: DATA_W];
   assign op        = cmd_empty ? '0 : head[5:0];

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb/tb_rx_cmd_parser.sv - randomized self-checking bench for rx_cmd_parser
// Reference model parses by byte position within the frame and keeps a command queue.
module tb_rx_cmd_parser;

   localparam int         DATA_W = 8;
   localparam int         DEPTH  = 4;
   localparam int         N      = DATA_W / 4;
   localparam int         CW     = $clog2(DEPTH) + 1;
   localparam logic [7:0] TERM   = 8'h0D;

   logic              clk, reset, rx_done_tick, rd;
   logic [7:0]        dout;
   logic [DATA_W-1:0] a, b;
   logic [5:0]        op;
   logic              cmd_empty, cmd_full, err, ovf;
   logic [CW-1:0]     count;

   rx_cmd_parser #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TERM(TERM)) dut (
      .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .dout(dout), .rd(rd),
      .a(a), .b(b), .op(op), .cmd_empty(cmd_empty), .cmd_full(cmd_full),
      .count(count), .err(err), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [5:0]        op;
   } cmd_t;

   cmd_t       q[$];
   int         pos;
   bit         syncing;
   logic [7:0] fb[2*N+2];
   int         checks   = 0;
   int         failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
   endfunction

   function automatic int m_hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return int'(c) - 55;
   endfunction

   function automatic bit m_opcode(input logic [7:0] c, output logic [5:0] code);
      code = 6'd0;
      case (c)
         "+": code = 6'b100000;
         "-": code = 6'b100010;
         "&": code = 6'b100100;
         "|": code = 6'b100101;
         "^": code = 6'b100110;
         "~": code = 6'b100111;
         "<": code = 6'b000010;
         ">": code = 6'b000011;
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   function automatic void m_clear();
      q.delete();
      pos     = 0;
      syncing = 1'b0;
   endfunction

   // One clock cycle: apply inputs, advance the model, compare everything observable.
   task automatic step(input bit tick, input logic [7:0] by, input bit r);
      bit         e_err, e_ovf, do_push, popped, ok;
      logic [5:0] code;
      cmd_t       c;
      rx_done_tick = tick;
      dout         = tick ? by : 8'($urandom);
      rd           = r;
      @(posedge clk);
      #1;
      e_err   = 1'b0;
      e_ovf   = 1'b0;
      do_push = 1'b0;
      popped  = r && q.size() > 0;
      if (tick) begin
         if (syncing) begin
            if (by == TERM) begin syncing = 1'b0; pos = 0; end
         end else if (!(pos == 0 && by == TERM)) begin
            if (pos < 2*N)       ok = m_is_hex(by);
            else if (pos == 2*N) ok = m_opcode(by, code);
            else                 ok = (by == TERM);
            if (ok) begin
               fb[pos] = by;
               pos++;
               if (pos == 2*N + 2) begin
                  c.a = '0;
                  c.b = '0;
                  for (int i = 0; i < N; i++) begin
                     c.a = DATA_W'(c.a * 16 + m_hexval(fb[i]));
                     c.b = DATA_W'(c.b * 16 + m_hexval(fb[N+i]));
                  end
                  void'(m_opcode(fb[2*N], c.op));
                  do_push = 1'b1;
                  pos     = 0;
               end
            end else begin
               e_err   = 1'b1;
               pos     = 0;
               syncing = (by != TERM);
            end
         end
      end
      if (popped) void'(q.pop_front());
      if (do_push) begin
         if (q.size() < DEPTH) q.push_back(c);
         else e_ovf = 1'b1;
      end
      rx_done_tick = 1'b0;
      rd           = 1'b0;
      check("err", err, e_err);
      check("ovf", ovf, e_ovf);
      check("count", count, q.size());
      check("empty", cmd_empty, q.size() == 0);
      check("full", cmd_full, q.size() == DEPTH);
      if (q.size() > 0) begin
         check("a", a, q[0].a);
         check("b", b, q[0].b);
         check("op", op, q[0].op);
      end
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
   endtask

   task automatic term(input bit r);
      step(1'b1, TERM, r);
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      m_clear();
      check("rst_count", count, 0);
      check("rst_empty", cmd_empty, 1);
      check("rst_full", cmd_full, 0);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_op", op, 0);
      check("rst_err", err, 0);
      check("rst_ovf", ovf, 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [7:0] hexchar(input int d, input bit up);
      if (d < 10) return 8'(48 + d);
      return up ? 8'(55 + d) : 8'(87 + d);
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] opch [8];
      logic [7:0] junk;
      string      f [5];
      opch = '{8'h2B, 8'h2D, 8'h26, 8'h7C, 8'h5E, 8'h7E, 8'h3C, 8'h3E};
      f    = '{"1011+", "2021-", "3031&", "4041|", "5051^"};
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      rd           = 1'b0;
      dout         = 8'h00;
      m_clear();
      do_reset();

      send("5f10+"); term(1'b0);
      check("t1_a", a, 8'h5F);
      check("t1_b", b, 8'h10);
      check("t1_op", op, 6'b100000);
      check("t1_count", count, 1);
      step(1'b0, 8'h00, 1'b1);
      check("t1_empty", cmd_empty, 1);

      send("5g");
      check("t2_err", err, 1);
      term(1'b0); send("A1b2-"); term(1'b0);
      check("t2_count", count, 1);
      check("t2_a", a, 8'hA1);
      check("t2_b", b, 8'hB2);
      check("t2_op", op, 6'b100010);
      step(1'b0, 8'h00, 1'b1);

      for (int k = 0; k < 5; k++) begin
         send(f[k]); term(1'b0);
         if (k == 3) check("t3_full", cmd_full, 1);
         if (k == 4) check("t3_ovf", ovf, 1);
      end
      for (int k = 0; k < 4; k++) begin
         check("t3_pop_a", a, 8'((k + 1) * 16));
         step(1'b0, 8'h00, 1'b1);
      end
      check("t3_empty", cmd_empty, 1);

      for (int k = 0; k < 5; k++) begin
         send(f[k]); term(k == 4);
      end
      check("t4_ovf", ovf, 0);
      check("t4_count", count, 4);
      for (int k = 1; k < 5; k++) begin
         check("t4_pop_a", a, 8'((k + 1) * 16));
         step(1'b0, 8'h00, 1'b1);
      end

      send("5f1");
      do_reset();
      send("0302&"); term(1'b0);
      check("t5_count", count, 1);
      check("t5_a", a, 8'h03);
      check("t5_b", b, 8'h02);
      check("t5_op", op, 6'b100100);
      step(1'b0, 8'h00, 1'b1);

      term(1'b0);
      check("t6_blank", count, 0);
      send("1234+x");
      check("t6_err", err, 1);
      step(1'b0, 8'h00, 1'b0);
      check("t6_count", count, 0);
      term(1'b0);

      for (int it = 0; it < 600; it++) begin
         int  sel;
         sel = $urandom_range(0, 9);
         for (int i = 0; i < 2*N + 2; i++) begin
            logic [7:0] c;
            if (i < 2*N)       c = hexchar($urandom_range(0, 15), 1'($urandom));
            else if (i == 2*N) c = opch[$urandom_range(0, 7)];
            else               c = TERM;
            if (sel == 0 && $urandom_range(0, 2*N + 1) == i) begin
               junk = 8'($urandom);
               c = ($urandom_range(0, 3) == 0) ? TERM : junk;
            end
            step(1'b1, c, $urandom_range(0, 9) < 3);
            if ($urandom_range(0, 4) == 0) step(1'b0, 8'h00, $urandom_range(0, 1) == 1);
         end
         if (sel == 1) term(1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
